// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : RV32I memory stage - data-bus req/ready access, store
//                    lane alignment, load extension and MEM/WB registers.
// Optional feature macro: MISALIGN_TRAP_EN (trap on misaligned H/W access).
// Revision: 1.0
// ============================================================================
module mem_access_stage #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int TMO_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  PIP_memOper_i,
    input  logic [31:0] PIP_alu_result_i,
    input  logic [31:0] PIP_second_operand_i,
    input  logic        PIP_use_mem_i,
    input  logic        PIP_write_reg_i,
    input  logic [4:0]  PIP_rd_i,
    input  logic        PIP_TRAP_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic        stall_o,
    output logic [31:0] PIP_mem_data_o,
    output logic [31:0] PIP_alu_result_o,
    output logic        PIP_use_mem_o,
    output logic        PIP_write_reg_o,
    output logic [4:0]  PIP_rd_o,
    output logic        PIP_TRAP_o,
    output logic [31:0] MEM_WB_operand_o
);

    localparam bit             TMO_EN  = (WAIT_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_VAL = TMO_W'(WAIT_TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [4:0]        oper_q, oper_d;

    logic [31:0]       mem_data_q, mem_data_d;
    logic [31:0]       alu_result_q, alu_result_d;
    logic              use_mem_q, use_mem_d;
    logic              write_reg_q, write_reg_d;
    logic [4:0]        rd_q, rd_d;
    logic              trap_q, trap_d;

    // Decode of the instruction currently presented by EX/MEM
    logic [1:0]  size;
    logic        is_mem;
    logic        access;
    logic        misalign_trap;
    logic [31:0] eff_addr;

    assign size   = PIP_memOper_i[1:0];
    assign is_mem = PIP_memOper_i[4] && (size != 2'b11);

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned    = ((size == 2'b01) && PIP_alu_result_i[0]) ||
                           ((size == 2'b10) && (PIP_alu_result_i[1:0] != 2'b00));
    assign misalign_trap = is_mem && !PIP_TRAP_i && misaligned;
    assign access        = is_mem && !PIP_TRAP_i && !misaligned;
    assign eff_addr      = PIP_alu_result_i;
`else
    // Sub-size address bits are forced to zero so the access stays aligned
    assign misalign_trap = 1'b0;
    assign access        = is_mem && !PIP_TRAP_i;
    always_comb begin
        eff_addr = PIP_alu_result_i;
        if (size == 2'b10)
            eff_addr[1:0] = 2'b00;
        else if (size == 2'b01)
            eff_addr[0] = 1'b0;
    end
`endif

    // Store lane placement for the current instruction
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    always_comb begin
        cur_be    = 4'b1111;
        cur_wdata = PIP_second_operand_i;
        case (size)
            2'b00: begin
                cur_be    = 4'b0001 << eff_addr[1:0];
                cur_wdata = {4{PIP_second_operand_i[7:0]}};
            end
            2'b01: begin
                cur_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
                cur_wdata = {2{PIP_second_operand_i[15:0]}};
            end
            default: ;
        endcase
    end

    // While waiting, extraction uses the values captured at issue
    logic [1:0]  sel_off;
    logic [4:0]  sel_oper;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign sel_off  = (state_q == S_WAIT) ? addr_q[1:0] : eff_addr[1:0];
    assign sel_oper = (state_q == S_WAIT) ? oper_q      : PIP_memOper_i;

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (sel_off)
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            2'b11:   ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = dmem_rdata_i[7:0];
        endcase
        ld_half = sel_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (sel_oper[1:0])
            2'b00:   load_ext = {{24{~sel_oper[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{~sel_oper[2] & ld_half[15]}}, ld_half};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    logic req;
    logic stall;
    logic complete;
    logic timeout;
    logic cur_we;
    logic is_store;
    logic [TMO_W-1:0] cnt_inc;

    assign cur_we   = access && PIP_memOper_i[3];
    assign is_store = sel_oper[4] && sel_oper[3];
    assign cnt_inc  = cnt_q + TMO_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        oper_d   = oper_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req = access;
                if (access && !dmem_ready_i) begin
                    stall   = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    addr_d  = eff_addr;
                    be_d    = cur_be;
                    wdata_d = cur_wdata;
                    we_d    = cur_we;
                    oper_d  = PIP_memOper_i;
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (dmem_ready_i) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (TMO_EN && (cnt_inc == TMO_VAL)) begin
                    complete = 1'b1;
                    timeout  = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MEM/WB register next values; non-completing cycles insert a bubble
    always_comb begin
        mem_data_d   = '0;
        alu_result_d = '0;
        use_mem_d    = 1'b0;
        write_reg_d  = 1'b0;
        rd_d         = '0;
        trap_d       = 1'b0;
        if (complete) begin
            alu_result_d = PIP_alu_result_i;
            use_mem_d    = PIP_use_mem_i;
            rd_d         = PIP_rd_i;
            trap_d       = PIP_TRAP_i || timeout || misalign_trap;
            write_reg_d  = PIP_write_reg_i && !is_store && !trap_d;
            if (req && dmem_ready_i && !is_store)
                mem_data_d = load_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            oper_q       <= '0;
            mem_data_q   <= '0;
            alu_result_q <= '0;
            use_mem_q    <= 1'b0;
            write_reg_q  <= 1'b0;
            rd_q         <= '0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            oper_q       <= oper_d;
            mem_data_q   <= mem_data_d;
            alu_result_q <= alu_result_d;
            use_mem_q    <= use_mem_d;
            write_reg_q  <= write_reg_d;
            rd_q         <= rd_d;
            trap_q       <= trap_d;
        end
    end

    // Gated by reset_n so an in-flight request disappears the moment reset hits
    assign dmem_req_o   = reset_n && req;
    assign stall_o      = reset_n && stall;
    assign dmem_we_o    = (state_q == S_WAIT) ? we_q : cur_we;
    assign dmem_addr_o  = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : {eff_addr[31:2], 2'b00};
    assign dmem_be_o    = (state_q == S_WAIT) ? be_q : cur_be;
    assign dmem_wdata_o = (state_q == S_WAIT) ? wdata_q : cur_wdata;

    assign PIP_mem_data_o   = mem_data_q;
    assign PIP_alu_result_o = alu_result_q;
    assign PIP_use_mem_o    = use_mem_q;
    assign PIP_write_reg_o  = write_reg_q;
    assign PIP_rd_o         = rd_q;
    assign PIP_TRAP_o       = trap_q;
    assign MEM_WB_operand_o = use_mem_q ? mem_data_q : alu_result_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
module tb_mem_access_stage;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LBU = 5'b10100;
    localparam logic [4:0] OP_LH  = 5'b10001;
    localparam logic [4:0] OP_LW  = 5'b10010;
    localparam logic [4:0] OP_SB  = 5'b11000;
    localparam logic [4:0] OP_SH  = 5'b11001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  mem_oper;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic        use_mem;
    logic        write_reg;
    logic [4:0]  rd;
    logic        trap_in;
    logic        req, we, ready, stall, use_mem_o, write_reg_o, trap_o;
    logic [31:0] addr, wdata, rdata, mem_data_o, alu_result_o, wb_operand;
    logic [3:0]  be;
    logic [4:0]  rd_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.WAIT_TIMEOUT(4), .TMO_W(8)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .PIP_memOper_i        (mem_oper),
        .PIP_alu_result_i     (alu_result),
        .PIP_second_operand_i (rs2),
        .PIP_use_mem_i        (use_mem),
        .PIP_write_reg_i      (write_reg),
        .PIP_rd_i             (rd),
        .PIP_TRAP_i           (trap_in),
        .dmem_req_o           (req),
        .dmem_we_o            (we),
        .dmem_addr_o          (addr),
        .dmem_be_o            (be),
        .dmem_wdata_o         (wdata),
        .dmem_rdata_i         (rdata),
        .dmem_ready_i         (ready),
        .stall_o              (stall),
        .PIP_mem_data_o       (mem_data_o),
        .PIP_alu_result_o     (alu_result_o),
        .PIP_use_mem_o        (use_mem_o),
        .PIP_write_reg_o      (write_reg_o),
        .PIP_rd_o             (rd_o),
        .PIP_TRAP_o           (trap_o),
        .MEM_WB_operand_o     (wb_operand)
    );

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic um, input logic wr, input logic [4:0] r,
                         input logic rdy, input logic [31:0] rdat);
        mem_oper   = op;
        alu_result = a;
        rs2        = d;
        use_mem    = um;
        write_reg  = wr;
        rd         = r;
        trap_in    = 1'b0;
        ready      = rdy;
        rdata      = rdat;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        #3;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if ({mem_data_o, alu_result_o, use_mem_o, write_reg_o, rd_o, trap_o} !== 72'h0)
            begin failures++; $display("FAIL reset_regs got data=%h alu=%h wr=%b rd=%0d trap=%b exp all 0",
                                       mem_data_o, alu_result_o, write_reg_o, rd_o, trap_o); end
        @(negedge clk);
        reset_n = 1'b1;
        next_edge();
    endtask

    task automatic test_nop_forward();
        drive(OP_NOP, 32'h000055AA, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1, 32'hFFFFFFFF);
        #1;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL nop_req got=%b exp=0", req); end
        next_edge();
        checks++; if (alu_result_o !== 32'h000055AA || write_reg_o !== 1'b1 || rd_o !== 5'd7 || mem_data_o !== 32'h0)
            begin failures++; $display("FAIL nop_fwd got alu=%h wr=%b rd=%0d data=%h exp alu=000055aa wr=1 rd=7 data=0",
                                       alu_result_o, write_reg_o, rd_o, mem_data_o); end
        checks++; if (wb_operand !== 32'h000055AA) begin failures++; $display("FAIL nop_wb_operand got=%h exp=000055aa", wb_operand); end
    endtask

    task automatic test_lw_zero_wait();
        drive(OP_LW, 32'h00000100, 32'h0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
        #1;
        checks++; if (req !== 1'b1 || stall !== 1'b0 || we !== 1'b0 || addr !== 32'h100 || be !== 4'b1111)
            begin failures++; $display("FAIL lw_bus got req=%b stall=%b we=%b addr=%h be=%b exp 1 0 0 00000100 1111",
                                       req, stall, we, addr, be); end
        next_edge();
        checks++; if (mem_data_o !== 32'hDEADBEEF || use_mem_o !== 1'b1 || write_reg_o !== 1'b1 || rd_o !== 5'd5)
            begin failures++; $display("FAIL lw_result got data=%h um=%b wr=%b rd=%0d exp deadbeef 1 1 5",
                                       mem_data_o, use_mem_o, write_reg_o, rd_o); end
        checks++; if (wb_operand !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_wb_operand got=%h exp=deadbeef", wb_operand); end
    endtask

    task automatic test_load_extend();
        drive(OP_LB, 32'h00000103, 32'h0, 1'b1, 1'b1, 5'd1, 1'b1, 32'h80112233);
        #1;
        checks++; if (be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", be); end
        next_edge();
        checks++; if (mem_data_o !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", mem_data_o); end
        drive(OP_LBU, 32'h00000103, 32'h0, 1'b1, 1'b1, 5'd1, 1'b1, 32'h80112233);
        next_edge();
        checks++; if (mem_data_o !== 32'h00000080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", mem_data_o); end
        drive(OP_LH, 32'h00000002, 32'h0, 1'b1, 1'b1, 5'd2, 1'b1, 32'h80011234);
        next_edge();
        checks++; if (mem_data_o !== 32'hFFFF8001) begin failures++; $display("FAIL lh_upper got=%h exp=ffff8001", mem_data_o); end
    endtask

    task automatic test_store_lanes();
        drive(OP_SH, 32'h00000022, 32'h0000ABCD, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0);
        #1;
        checks++; if (be !== 4'b1100 || wdata !== 32'hABCDABCD || we !== 1'b1 || req !== 1'b1 || addr !== 32'h20)
            begin failures++; $display("FAIL sh_bus got be=%b wdata=%h we=%b req=%b addr=%h exp 1100 abcdabcd 1 1 00000020",
                                       be, wdata, we, req, addr); end
        next_edge();
        checks++; if (write_reg_o !== 1'b0) begin failures++; $display("FAIL sh_write_reg got=%b exp=0", write_reg_o); end
        drive(OP_SB, 32'h00000041, 32'h123456EF, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0);
        #1;
        checks++; if (be !== 4'b0010 || wdata !== 32'hEFEFEFEF)
            begin failures++; $display("FAIL sb_lanes got be=%b wdata=%h exp 0010 efefefef", be, wdata); end
        next_edge();
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_ready();
        drive(OP_LW, 32'h00000200, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1 || req !== 1'b1 || addr !== 32'h200)
                begin failures++; $display("FAIL wait_stall[%0d] got stall=%b req=%b addr=%h exp 1 1 00000200", i, stall, req, addr); end
            next_edge();
            checks++; if (write_reg_o !== 1'b0 || rd_o !== 5'd0 || use_mem_o !== 1'b0)
                begin failures++; $display("FAIL wait_bubble[%0d] got wr=%b rd=%0d um=%b exp 0 0 0", i, write_reg_o, rd_o, use_mem_o); end
        end
        ready = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || req !== 1'b1) begin failures++; $display("FAIL wait_done_stall got stall=%b req=%b exp 0 1", stall, req); end
        next_edge();
        checks++; if (mem_data_o !== 32'h12345678 || write_reg_o !== 1'b1 || rd_o !== 5'd9)
            begin failures++; $display("FAIL wait_result got data=%h wr=%b rd=%0d exp 12345678 1 9", mem_data_o, write_reg_o, rd_o); end
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_timeout();
        drive(OP_LW, 32'h00000300, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL tmo_stall[%0d] got=%b exp=1", i, stall); end
            next_edge();
        end
        #1;
        checks++; if (stall !== 1'b0 || req !== 1'b1) begin failures++; $display("FAIL tmo_release got stall=%b req=%b exp 0 1", stall, req); end
        next_edge();
        checks++; if (trap_o !== 1'b1 || write_reg_o !== 1'b0)
            begin failures++; $display("FAIL tmo_trap got trap=%b wr=%b exp 1 0", trap_o, write_reg_o); end
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL tmo_idle got req=%b stall=%b exp 0 0", req, stall); end
        next_edge();
    endtask

    task automatic test_reset_mid_wait();
        drive(OP_LW, 32'h00000400, 32'h0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
        next_edge();
        checks++; if (stall !== 1'b1 || req !== 1'b1) begin failures++; $display("FAIL rstw_inwait got stall=%b req=%b exp 1 1", stall, req); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstw_drop got req=%b stall=%b exp 0 0", req, stall); end
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        next_edge();
        drive(OP_LW, 32'h00000500, 32'h0, 1'b1, 1'b1, 5'd8, 1'b1, 32'h0BADF00D);
        #1;
        checks++; if (stall !== 1'b0 || addr !== 32'h500) begin failures++; $display("FAIL rstw_idle got stall=%b addr=%h exp 0 00000500", stall, addr); end
        next_edge();
        checks++; if (mem_data_o !== 32'h0BADF00D) begin failures++; $display("FAIL rstw_after got=%h exp=0badf00d", mem_data_o); end
    endtask

    task automatic test_misalign();
        drive(OP_LW, 32'h00000102, 32'h0, 1'b1, 1'b1, 5'd10, 1'b1, 32'hCAFEF00D);
        #1;
`ifdef MISALIGN_TRAP_EN
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mis_noreq got req=%b stall=%b exp 0 0", req, stall); end
        next_edge();
        checks++; if (trap_o !== 1'b1 || write_reg_o !== 1'b0)
            begin failures++; $display("FAIL mis_trap got trap=%b wr=%b exp 1 0", trap_o, write_reg_o); end
`else
        checks++; if (req !== 1'b1 || addr !== 32'h100 || be !== 4'b1111)
            begin failures++; $display("FAIL mis_align got req=%b addr=%h be=%b exp 1 00000100 1111", req, addr, be); end
        next_edge();
        checks++; if (mem_data_o !== 32'hCAFEF00D || trap_o !== 1'b0)
            begin failures++; $display("FAIL mis_result got data=%h trap=%b exp cafef00d 0", mem_data_o, trap_o); end
`endif
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_nop_forward();
        test_lw_zero_wait();
        test_load_extend();
        test_store_lanes();
        test_wait_ready();
        test_timeout();
        test_reset_mid_wait();
        test_misalign();
        next_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory stage of the pipelined RV32I core, directly downstream of execute. Consumes the EX/MEM pipeline registers and issues load/store requests to the data memory over a req/ready handshake. Aligns store data into byte lanes and sign/zero-extends load data. Stalls the front of the pipe while an access is outstanding and registers the MEM/WB pipeline outputs.

Parameters:
WAIT_TIMEOUT, 255, max cycles in WAIT before bus-error trap; 0 disables the timeout
TMO_W, 8, width of the wait counter; must hold WAIT_TIMEOUT

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
PIP_memOper_i  in  5  [4]=access, [3]=store, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W, 11 reserved = no access)
PIP_alu_result_i  in  32  effective address, or result to forward
PIP_second_operand_i  in  32  store data (rs2)
PIP_use_mem_i  in  1  WB selects load data
PIP_write_reg_i  in  1  WB writes rd
PIP_rd_i  in  5  destination register
PIP_TRAP_i  in  1  trap from earlier stages
dmem_req_o  out  1  access request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_rdata_i  in  32  read data; valid when dmem_ready_i=1
dmem_ready_i  in  1  access complete this cycle
stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
PIP_mem_data_o  out  32  extended load data
PIP_alu_result_o  out  32  forwarded ALU result
PIP_use_mem_o  out  1  forwarded
PIP_write_reg_o  out  1  forwarded, gated
PIP_rd_o  out  5  forwarded
PIP_TRAP_o  out  1  trap out
MEM_WB_operand_o  out  32  PIP_use_mem_o ? PIP_mem_data_o : PIP_alu_result_o (combinational, for forwarding into execute)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, wait counter=0, all registered outputs=0; dmem_req_o and stall_o drop immediately, including mid-access. Any access in flight is abandoned.
- Access = memOper[4] && size!=11 && !PIP_TRAP_i && !misaligned. Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
- States: IDLE, WAIT.
- IDLE: dmem_req_o = access (combinational from inputs).
  - No access, or ready=1 in the same cycle: complete this cycle (zero-wait), stall_o=0, no state change.
  - Access with ready=0: go to WAIT and latch addr, be, wdata, we and memOper. stall_o=1 from this cycle.
- WAIT: dmem_req_o=1 from latched values, stable until ready. stall_o=1 while ready=0.
  - ready=1: complete, stall_o=0 this cycle, return to IDLE.
- Timeout: counter increments each WAIT cycle. When it reaches WAIT_TIMEOUT with ready still 0:
  - complete with PIP_TRAP_o=1 and PIP_write_reg_o=0; return to IDLE and drop req next cycle.
- Stall cycles register a bubble: write_reg, use_mem and TRAP = 0; rd = 0.
- Completion cycle registers outputs normally. A store forces PIP_write_reg_o=0.
- Store lanes (off=addr[1:0]):
  - B: be=0001<<off, wdata={4{rs2[7:0]}}
  - H: be = off[1] ? 1100 : 0011, wdata={2{rs2[15:0]}}
  - W: be=1111
- Load extract: B takes rdata byte off; H takes the half selected by off[1]. Sign-extend unless memOper[2]. W is passed through.
- Non-access instructions: mem_data=0, other fields forwarded, one-cycle latency.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a misaligned access issues no request, registers PIP_TRAP_o=1 and PIP_write_reg_o=0, with no stall.
- Undefined: misalignment is ignored. Address bits below the access size are treated as 0 (H clears addr[0], W clears addr[1:0]) and the access proceeds normally.

Test Plan:
- LW addr 0x100, ready=1 same cycle, rdata=0xDEADBEEF -> no stall; next edge mem_data=0xDEADBEEF, use_mem=1, write_reg=1.
- LB addr 0x103, rdata=0x80112233 -> mem_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x22, rs2=0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1; write_reg_o=0.
- LW with ready delayed 3 cycles -> stall_o=1 for 3 cycles with req/addr stable; 3 bubbles, then result registered.
- WAIT_TIMEOUT=4, ready never asserted -> trap out after 4 WAIT cycles, req drops, stall releases. Async reset asserted during WAIT -> req=0 and stall=0 immediately.
- With MISALIGN_TRAP_EN, LW addr 0x102 -> req=0, TRAP_o=1. Without it -> req to 0x100, be=1111.
